// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state encoding, block/key widths and GF(2^8) helpers.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;
  localparam int KEYS_W  = 1408;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_state_e;

  // Multiply by x in GF(2^8), reducing by 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               final_round,
  output logic [BLOCK_W-1:0] state_out
);

  // Byte i = 4*col + row, byte 0 is the most significant byte of the block.
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    sbox u_sbox (
      .in_byte  (state_in[BLOCK_W-1-8*i -: 8]),
      .out_byte (sb[i])
    );
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_out[BLOCK_W-1-8*i -: 8] =
      (final_round ? sr[i] : mc[i]) ^ round_key[BLOCK_W-1-8*i -: 8];
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a constant lookup table (byte 0x00 entry in the top byte).
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n sits at bit offset (255-n)*8; ~in_byte gives 255-n directly.
  assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready in and out.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KEYS_W-1:0]  key_array,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               busy
);

  aes_state_e         fsm, fsm_next;
  logic [BLOCK_W-1:0] state_reg, state_next;
  logic [3:0]         round_cnt, round_cnt_next;
  logic [BLOCK_W-1:0] rk_tab [NR+1];
  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] round_out;
  logic               final_round;

  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign rk_tab[g] = key_array[BLOCK_W*g +: BLOCK_W];
  end

  assign round_key   = (round_cnt <= 4'(NR)) ? rk_tab[round_cnt] : '0;
  assign final_round = (round_cnt == 4'(NR));

  aes_round u_round (
    .state_in    (state_reg),
    .round_key   (round_key),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state_reg <= '0;
      round_cnt <= '0;
    end else begin
      fsm       <= fsm_next;
      state_reg <= state_next;
      round_cnt <= round_cnt_next;
    end
  end

  always_comb begin
    fsm_next       = fsm;
    state_next     = state_reg;
    round_cnt_next = round_cnt;
    case (fsm)
      IDLE: begin
        if (in_valid && in_ready) begin
          fsm_next       = ROUND;
          state_next     = plaintext ^ rk_tab[0];
          round_cnt_next = 4'd1;
        end
      end
      ROUND: begin
        if (round_cnt > 4'(NR)) begin
          fsm_next = IDLE;
        end else begin
          state_next     = round_out;
          round_cnt_next = round_cnt + 4'd1;
          if (final_round) begin
            fsm_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign in_ready   = (fsm == IDLE) && !rst;
  assign out_valid  = (fsm == DONE);
  assign busy       = (fsm == ROUND);
  assign ciphertext = state_reg;

endmodule
